// File: rtl/hynoc_pkg.sv
// Shared HyNoC definitions: FSM encoding, flit tail-bit position and FIFO depth.
package hynoc_pkg;

  localparam logic STATE_IDLE   = 1'b0;
  localparam logic STATE_LOCKED = 1'b1;

  // The last-flit marker always lives in the top bit of a flit.
  function automatic int tail_bit(input int flit_width);
    return flit_width - 1;
  endfunction

  function automatic int fifo_depth(input int log2_depth);
    return 1 << log2_depth;
  endfunction

endpackage

// File: rtl/hynoc_rr_arbiter.sv
// Combinational round-robin picker: one-hot of the first request at or above rr_ptr, wrapping.
module hynoc_rr_arbiter #(
  parameter int NB_PORTS  = 3,
  parameter int PTR_WIDTH = $clog2(NB_PORTS)
) (
  input  logic [NB_PORTS-1:0]  req,
  input  logic [PTR_WIDTH-1:0] rr_ptr,
  output logic [NB_PORTS-1:0]  pick
);

  logic [NB_PORTS-1:0] hi_mask;
  logic [NB_PORTS-1:0] hi_req;
  logic [NB_PORTS-1:0] candidates;

  // Requests at or above the pointer win; otherwise wrap to the lowest request.
  assign hi_mask    = {NB_PORTS{1'b1}} << rr_ptr;
  assign hi_req     = req & hi_mask;
  assign candidates = (|hi_req) ? hi_req : req;

  // NOTE: pick gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    pick = '0;
    for (int i = NB_PORTS - 1; i >= 0; i--) begin
      if (candidates[i]) pick = NB_PORTS'(1) << i;
    end
  end

endmodule

// File: rtl/hynoc_egress_port.sv
// N-input wormhole egress stage: round-robin packet arbitration with per-packet grant lock,
// registered egress write gated by downstream FIFO level, and a forwarded-packet counter.
module hynoc_egress_port
  import hynoc_pkg::*;
#(
  parameter int NB_PORTS        = 3,
  parameter int PAYLOAD_WIDTH   = 32,
  parameter int FLIT_WIDTH      = PAYLOAD_WIDTH + 1,
  parameter int LOG2_FIFO_DEPTH = 5,
  parameter int LEVEL_MARGIN    = 3,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                           router_clk,
  input  logic                           router_rst_n,
  input  logic [NB_PORTS-1:0]            in_valid,
  input  logic [NB_PORTS*FLIT_WIDTH-1:0] in_data,
  output logic [NB_PORTS-1:0]            in_ready,
  input  logic [NB_PORTS-1:0]            in_mask,
  output logic                           egress_write,
  output logic [FLIT_WIDTH-1:0]          egress_data,
  input  logic [LOG2_FIFO_DEPTH:0]       egress_fifo_level,
  output logic [NB_PORTS-1:0]            grant,
  output logic                           busy,
  output logic [COUNT_WIDTH-1:0]         pkt_count
);

  localparam int PTR_WIDTH   = $clog2(NB_PORTS);
  localparam int TAIL        = tail_bit(FLIT_WIDTH);
  localparam int FIFO_DEPTH  = fifo_depth(LOG2_FIFO_DEPTH);
  localparam int LEVEL_WIDTH = LOG2_FIFO_DEPTH + 1;
  localparam logic [LEVEL_WIDTH-1:0] THRESHOLD = LEVEL_WIDTH'(FIFO_DEPTH - 1 - LEVEL_MARGIN);

  logic                  state;
  logic [PTR_WIDTH-1:0]  rr_ptr;
  logic [PTR_WIDTH-1:0]  next_ptr;
  logic [NB_PORTS-1:0]   req;
  logic [NB_PORTS-1:0]   pick;
  logic [PTR_WIDTH-1:0]  grant_idx;
  logic [FLIT_WIDTH-1:0] grant_flit;
  logic                  grant_valid;
  logic                  space_ok;
  logic                  transfer;
  logic                  tail_xfer;

  // in_mask only matters while choosing a new owner; a locked packet ignores it.
  assign req = (state == STATE_IDLE) ? (in_valid & in_mask) : '0;

  hynoc_rr_arbiter #(
    .NB_PORTS (NB_PORTS),
    .PTR_WIDTH(PTR_WIDTH)
  ) u_arbiter (
    .req   (req),
    .rr_ptr(rr_ptr),
    .pick  (pick)
  );

  always_comb begin
    grant_idx   = '0;
    grant_flit  = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < NB_PORTS; i++) begin
      if (grant[i]) begin
        grant_idx   = PTR_WIDTH'(i);
        grant_flit  = in_data[i*FLIT_WIDTH +: FLIT_WIDTH];
        grant_valid = in_valid[i];
      end
    end
  end

  // Margin below full absorbs the latency of the level report from downstream.
  assign space_ok  = (egress_fifo_level <= THRESHOLD);
  assign busy      = (state == STATE_LOCKED);
  assign in_ready  = (busy && space_ok) ? grant : '0;
  assign transfer  = busy && space_ok && grant_valid;
  assign tail_xfer = transfer && grant_flit[TAIL];
  assign next_ptr  = (grant_idx == PTR_WIDTH'(NB_PORTS - 1)) ? '0 : grant_idx + PTR_WIDTH'(1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge router_clk or negedge router_rst_n) begin
    if (!router_rst_n) begin
      state  <= STATE_IDLE;
      rr_ptr <= '0;
      grant  <= '0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (|req) begin
            grant <= pick;
            state <= STATE_LOCKED;
          end
        end
        STATE_LOCKED: begin
          if (tail_xfer) begin
            state  <= STATE_IDLE;
            grant  <= '0;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

  // egress_data holds the last flit between writes; only the strobe returns to zero.
  always_ff @(posedge router_clk or negedge router_rst_n) begin
    if (!router_rst_n) begin
      egress_write <= 1'b0;
      egress_data  <= '0;
    end else begin
      egress_write <= transfer;
      if (transfer) egress_data <= grant_flit;
    end
  end

  // Counts tails as they leave the output register, wrapping naturally.
  always_ff @(posedge router_clk or negedge router_rst_n) begin
    if (!router_rst_n) begin
      pkt_count <= '0;
    end else if (egress_write && egress_data[TAIL]) begin
      pkt_count <= pkt_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hynoc_egress_port.sv
// Scoreboard bench for hynoc_egress_port: directed packets, monitor compares every egress write.
module tb_hynoc_egress_port;

  localparam int NP = 4;
  localparam int PW = 8;
  localparam int FW = PW + 1;
  localparam int LD = 5;
  localparam int CW = 4;

  logic            router_clk;
  logic            router_rst_n;
  logic [NP-1:0]   in_valid;
  logic [NP*FW-1:0] in_data;
  logic [NP-1:0]   in_ready;
  logic [NP-1:0]   in_mask;
  logic            egress_write;
  logic [FW-1:0]   egress_data;
  logic [LD:0]     egress_fifo_level;
  logic [NP-1:0]   grant;
  logic            busy;
  logic [CW-1:0]   pkt_count;

  hynoc_egress_port #(
    .NB_PORTS       (NP),
    .PAYLOAD_WIDTH  (PW),
    .FLIT_WIDTH     (FW),
    .LOG2_FIFO_DEPTH(LD),
    .LEVEL_MARGIN   (3),
    .COUNT_WIDTH    (CW)
  ) dut (
    .router_clk       (router_clk),
    .router_rst_n     (router_rst_n),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .in_mask          (in_mask),
    .egress_write     (egress_write),
    .egress_data      (egress_data),
    .egress_fifo_level(egress_fifo_level),
    .grant            (grant),
    .busy             (busy),
    .pkt_count        (pkt_count)
  );

  initial router_clk = 1'b0;
  always #5 router_clk = ~router_clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  logic [FW-1:0] src_q [NP][$];
  logic [FW-1:0] exp_q [$];
  int            wr_cycles [$];
  logic [5:0]    seq = '0;
  logic [NP-1:0] fire;
  logic [NP-1:0] ready_seen;
  logic [NP-1:0] grant_seen;

  always @(posedge router_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every egress write must match the next expected flit.
  always @(negedge router_clk) begin
    if (router_rst_n && egress_write) begin
      wr_cycles.push_back(cyc);
      if (exp_q.size() == 0) check("write with empty scoreboard", exp_q.size(), 1);
      else check("egress_data", 32'(egress_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic add_pkt(input int port, input int len);
    logic [FW-1:0] f;
    for (int k = 0; k < len; k++) begin
      f = {(k == len - 1), 2'(port), seq};
      seq++;
      src_q[port].push_back(f);
      exp_q.push_back(f);
    end
  endtask

  task automatic apply_inputs();
    for (int p = 0; p < NP; p++) begin
      in_valid[p] = (src_q[p].size() != 0);
      in_data[p*FW +: FW] = in_valid[p] ? src_q[p][0] : '0;
    end
  endtask

  task automatic step();
    apply_inputs();
    #1;
    fire = in_valid & in_ready;
    ready_seen = in_ready;
    @(posedge router_clk);
    for (int p = 0; p < NP; p++) if (fire[p]) void'(src_q[p].pop_front());
    @(negedge router_clk);
    #1;
    grant_seen |= grant;
  endtask

  function automatic bit pending();
    for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input int max);
    int n = 0;
    while ((pending() || exp_q.size() != 0) && n < max) begin
      step();
      n++;
    end
    check("drain scoreboard empty", exp_q.size(), 0);
    step();
    step();
  endtask

  task automatic reset_dut();
    router_rst_n = 1'b0;
    for (int p = 0; p < NP; p++) src_q[p].delete();
    exp_q.delete();
    wr_cycles.delete();
    apply_inputs();
    repeat (2) @(negedge router_clk);
    #1 router_rst_n = 1'b1;
    @(negedge router_clk);
    #1;
    grant_seen = '0;
  endtask

  initial begin
    #50000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    int c0;
    int bad;
    in_valid = '0;
    in_data = '0;
    in_mask = '1;
    egress_fifo_level = '0;
    router_rst_n = 1'b0;

    reset_dut();
    check("reset egress_write", 32'(egress_write), 0);
    check("reset egress_data", 32'(egress_data), 0);
    check("reset grant", 32'(grant), 0);
    check("reset busy", 32'(busy), 0);
    check("reset in_ready", 32'(in_ready), 0);
    check("reset pkt_count", 32'(pkt_count), 0);

    // Single stream: port 2, 4 flits.
    add_pkt(2, 4);
    c0 = cyc;
    step();
    check("single grant", 32'(grant), 32'h4);
    check("single busy", 32'(busy), 1);
    drain(30);
    check("single write count", wr_cycles.size(), 4);
    if (wr_cycles.size() == 4) begin
      check("single latency", wr_cycles[0] - c0, 2);
      check("single consecutive", wr_cycles[3] - wr_cycles[0], 3);
    end
    check("single pkt_count", 32'(pkt_count), 1);
    check("single released grant", 32'(grant), 0);

    // Fairness: 2 rounds of 2-flit packets from every port.
    reset_dut();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) add_pkt(p, 2);
    drain(100);
    check("fair write count", wr_cycles.size(), 16);
    bad = 0;
    if (wr_cycles.size() == 16) begin
      for (int k = 0; k < 8; k++) begin
        if (wr_cycles[2*k+1] - wr_cycles[2*k] != 1) bad++;
        if (k > 0 && wr_cycles[2*k] - wr_cycles[2*k-1] != 2) bad++;
      end
    end
    check("fair spacing errors", bad, 0);
    check("fair pkt_count", 32'(pkt_count), 8);

    // Flow control around the threshold of 28.
    reset_dut();
    egress_fifo_level = 6'd28;
    add_pkt(0, 6);
    step();
    step();
    check("ready at threshold", 32'(ready_seen), 32'h1);
    step();
    egress_fifo_level = 6'd29;
    step();
    check("ready above threshold", 32'(ready_seen), 0);
    check("write stalled", 32'(egress_write), 0);
    step();
    check("write still stalled", 32'(egress_write), 0);
    egress_fifo_level = 6'd28;
    drain(40);
    check("flow write count", wr_cycles.size(), 6);
    check("flow pkt_count", 32'(pkt_count), 1);

    // Mask: port 1 excluded; dropping port 0 mask mid-packet keeps the packet.
    reset_dut();
    egress_fifo_level = '0;
    in_mask = 4'b1101;
    add_pkt(0, 3);
    add_pkt(2, 1);
    add_pkt(3, 1);
    add_pkt(1, 1);
    step();
    check("mask first grant", 32'(grant), 32'h1);
    step();
    in_mask = 4'b1100;
    for (int n = 0; n < 30 && exp_q.size() > 1; n++) step();
    repeat (3) step();
    check("mask grants seen", 32'(grant_seen), 32'hd);
    check("mask idle with port 1 pending", 32'(busy), 0);
    check("mask port 1 waiting", exp_q.size(), 1);
    in_mask = 4'b1111;
    drain(30);
    check("mask pkt_count", 32'(pkt_count), 4);

    // Reset mid-packet, then rr_ptr must be back at 0.
    reset_dut();
    add_pkt(1, 2);
    drain(30);
    check("pre-reset pkt_count", 32'(pkt_count), 1);
    add_pkt(2, 5);
    step();
    step();
    step();
    check("pre-reset write", 32'(egress_write), 1);
    #1 router_rst_n = 1'b0;
    #1;
    check("async egress_write", 32'(egress_write), 0);
    check("async egress_data", 32'(egress_data), 0);
    check("async grant", 32'(grant), 0);
    check("async busy", 32'(busy), 0);
    check("async in_ready", 32'(in_ready), 0);
    check("async pkt_count", 32'(pkt_count), 0);
    reset_dut();
    add_pkt(1, 1);
    add_pkt(3, 1);
    step();
    check("post-reset grant", 32'(grant), 32'h2);
    drain(30);
    check("post-reset pkt_count", 32'(pkt_count), 2);

    // Counter wrap with a 4-bit counter: 17 single-flit packets.
    reset_dut();
    for (int k = 0; k < 17; k++) add_pkt(0, 1);
    drain(100);
    check("wrap pkt_count", 32'(pkt_count), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hynoc_egress_port.md
# hynoc_egress_port

Parametrised N-input wormhole egress stage for HyNoC routers. It arbitrates round-robin among NB_PORTS ingress flit streams and locks the grant for a whole packet. It forwards flits to one egress link, gated by the downstream FIFO level. It is the per-output building block for routers of any port count and replaces fixed-port-count egress logic.

## Interface
Parameters:
- NB_PORTS, 3: number of competing ingress streams (≥2).
- PAYLOAD_WIDTH, 32: flit payload width.
- FLIT_WIDTH, PAYLOAD_WIDTH+1: flit width; bit FLIT_WIDTH-1 is the tail (last-flit) marker.
- LOG2_FIFO_DEPTH, 5: log2 depth of the downstream FIFO; FIFO_DEPTH = 2**LOG2_FIFO_DEPTH.
- LEVEL_MARGIN, 3: free slots reserved to cover level-report latency; must be < FIFO_DEPTH.
- COUNT_WIDTH, 16: width of the forwarded-packet counter.

Ports:
- Clocking and reset (already decided): one clock, router_clk; reset is asynchronous and active-low, router_rst_n.
- router_clk, in, 1: single clock.
- router_rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, NB_PORTS: per-stream flit valid.
- in_data, in, NB_PORTS*FLIT_WIDTH: per-stream flit; stream i occupies [i*FLIT_WIDTH +: FLIT_WIDTH].
- in_ready, out, NB_PORTS: per-stream accept.
- in_mask, in, NB_PORTS: 1 = stream may win arbitration.
- egress_write, out, 1: registered write strobe to the downstream FIFO.
- egress_data, out, FLIT_WIDTH: registered flit.
- egress_fifo_level, in, LOG2_FIFO_DEPTH+1: downstream FIFO occupancy.
- grant, out, NB_PORTS: one-hot current owner; zero when idle.
- busy, out, 1: high in LOCKED.
- pkt_count, out, COUNT_WIDTH: number of tail flits written; wraps.

## Operation
- FSM states: IDLE, LOCKED.
- IDLE:
  - req = in_valid & in_mask.
  - If req ≠ 0, the round-robin picker selects the first set bit at or above rr_ptr, wrapping.
  - The grant register is loaded and the FSM moves to LOCKED at the next edge.
  - in_ready = 0.
- LOCKED:
  - space_ok = (egress_fifo_level ≤ FIFO_DEPTH-1-LEVEL_MARGIN), compared at LOG2_FIFO_DEPTH+1 bits.
  - in_ready[g] = space_ok for the granted stream g; 0 for all others.
  - Transfer = in_valid[g] & in_ready[g].
  - On a transfer with tail bit = 1: FSM → IDLE, rr_ptr ← (g+1) mod NB_PORTS, grant ← 0.
- Single-flit packets (tail bit set on the first flit) lock and release in one transfer.
- in_mask is sampled only in IDLE. Deasserting in_mask[g] mid-packet does not abort the packet.
- in_valid dropping mid-packet holds LOCKED indefinitely; there is no timeout.
- Output register: on a transfer, egress_write ← 1 and egress_data ← the flit. Otherwise egress_write ← 0 and egress_data holds its value.
- pkt_count increments on each cycle where egress_write = 1 and egress_data[FLIT_WIDTH-1] = 1. It wraps from 2**COUNT_WIDTH-1 to 0.
- Reset values: FSM IDLE, rr_ptr 0, grant 0, busy 0, in_ready 0, egress_write 0, egress_data 0, pkt_count 0.
- Reset is honoured mid-packet. The partial packet is dropped and there is no downstream cleanup; the upstream and downstream are reset together.

## Timing
- in_valid asserted in IDLE → grant visible after 1 edge → first transfer in that cycle if space_ok → egress_write 1 cycle later. Minimum latency is 2 cycles.
- Steady state: 1 flit/cycle while space_ok and in_valid hold.
- Packet boundary: the tail transfer is followed by one IDLE bubble cycle, so back-to-back packets sustain at most 1 flit/cycle with one idle cycle per packet.
- space_ok is combinational on egress_fifo_level; in_ready falls in the same cycle the level crosses the threshold.
- Level equal to the threshold still allows writes; threshold + 1 stalls.
- Simultaneous events: a tail transfer in the same cycle as new requests → the new grant is chosen in the following IDLE cycle, using the updated rr_ptr.

## Structure
- Shared hynoc definitions hold:
  - the tail-bit index (FLIT_WIDTH-1);
  - the FSM state encoding (IDLE = 1'b0, LOCKED = 1'b1);
  - the FIFO_DEPTH derivation.
- Sub-module hynoc_rr_arbiter: combinational round-robin picker, parameter NB_PORTS; inputs req and rr_ptr, output one-hot pick. Reusable by other HyNoC arbiters.

## Test plan
All scenarios use NB_PORTS=4, LOG2_FIFO_DEPTH=5, LEVEL_MARGIN=3 (threshold 28) unless stated.
- Single stream: port 2 sends a 4-flit packet with level 0 → egress_write on 4 consecutive cycles starting 2 cycles after in_valid; pkt_count = 1; grant = 4'b0100 during the packet.
- Fairness: all 4 ports continuously offer 2-flit packets → grant order 0,1,2,3,0…, each packet separated by exactly 1 idle cycle; pkt_count = 8 after 8 packets.
- Flow control: level = 28 → transfers proceed; level forced to 29 mid-packet → in_ready = 0 that cycle and egress_write = 0 the next cycle; level back to 28 → resume with no flit lost or duplicated.
- Mask: in_mask = 4'b1101 with all valid → port 1 is never granted; clearing mask bit 0 mid-packet of port 0 → the packet completes.
- Reset mid-packet: assert router_rst_n low asynchronously during flit 2 of 5 → outputs at reset values immediately; after release, a new request from port 3 is granted with rr_ptr = 0 priority applied.
- Counter wrap: COUNT_WIDTH=4, 17 single-flit packets → pkt_count = 1.
